// File: rtl/debug_frame_serializer_pkg.sv
// debug_frame_serializer_pkg: debug-bus constants and serializer state encoding shared with the debug controllers
package debug_frame_serializer_pkg;
  localparam logic [5:0] DBG_IDLE_SELECT = 6'b111111;
  localparam int DBG_N_CONTROLLERS = 4;
  localparam int DBG_CTRL_FIRST = 0;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_PARK,
    ST_LOAD,
    ST_WAIT_TX,
    ST_NEXT
  } state_t;
endpackage

// File: rtl/debug_byte_mux.sv
// debug_byte_mux: picks the byte_idx-th byte of a frame, least significant byte at index 0
module debug_byte_mux
  import debug_frame_serializer_pkg::*;
#(
  parameter int NB_FRAME = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_IDX = 2
) (
  input  logic [NB_FRAME-1:0] i_frame,
  input  logic [NB_IDX-1:0]   i_byte_idx,
  output logic [NB_BYTE-1:0]  o_byte
);
  // byte slice addressed by the index
  always_comb o_byte = i_frame[int'(i_byte_idx)*NB_BYTE +: NB_BYTE];
endmodule

// File: rtl/debug_frame_serializer.sv
// debug_frame_serializer: polls every debug controller in turn and streams each returned frame out byte by byte
module debug_frame_serializer
  import debug_frame_serializer_pkg::*;
#(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_BYTE = 8,
  parameter int N_CONTROLLERS = DBG_N_CONTROLLERS,
  parameter int NB_TIMEOUT = 4,
  parameter logic [5:0] IDLE_SELECT = DBG_IDLE_SELECT
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  output logic [5:0]                  o_request_select,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_controller,
  input  logic                        i_writing,
  output logic [NB_BYTE-1:0]          o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error
);
  localparam int N_BYTES = NB_CONTROL_FRAME / NB_BYTE;
  localparam int NB_IDX = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam int NB_ID = N_CONTROLLERS > 1 ? $clog2(N_CONTROLLERS) : 1;
  localparam logic [NB_IDX-1:0] LAST_BYTE = NB_IDX'(N_BYTES - 1);
  localparam logic [NB_ID-1:0] LAST_ID = NB_ID'(N_CONTROLLERS - 1);
  state_t state_q, state_d;
  logic [NB_ID-1:0] id_q, id_d;
  logic [NB_IDX-1:0] byte_idx_q, byte_idx_d;
  logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
  logic [NB_CONTROL_FRAME-1:0] frame_q, frame_d;
  logic error_q, error_d;
  logic tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic [NB_BYTE-1:0] cur_byte;
  debug_byte_mux #(
    .NB_FRAME(NB_CONTROL_FRAME),
    .NB_BYTE (NB_BYTE),
    .NB_IDX  (NB_IDX)
  ) u_byte_mux (
    .i_frame   (frame_q),
    .i_byte_idx(byte_idx_q),
    .o_byte    (cur_byte)
  );
  assign o_busy = state_q != ST_IDLE;
  assign o_error = error_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data = tx_data_q;
  // next state, datapath updates and the select/done outputs
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    byte_idx_d = byte_idx_q;
    tmo_d = tmo_q;
    frame_d = frame_q;
    error_d = error_q;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    o_request_select = IDLE_SELECT;
    o_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          id_d = NB_ID'(DBG_CTRL_FIRST);
          error_d = 1'b0;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        o_request_select = 6'(id_q);
        tmo_d = tmo_q + 1'b1;
        if (i_writing) begin
          frame_d = i_frame_from_controller;
          state_d = ST_PARK;
        end else if (&tmo_d) begin
          frame_d = '1;
          error_d = 1'b1;
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        byte_idx_d = '0;
        tmo_d = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_data_d = cur_byte;
        tx_start_d = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          byte_idx_d = byte_idx_q == LAST_BYTE ? byte_idx_q : byte_idx_q + 1'b1;
          state_d = byte_idx_q == LAST_BYTE ? ST_NEXT : ST_LOAD;
        end
      end
      ST_NEXT: begin
        o_done = id_q == LAST_ID;
        id_d = id_q == LAST_ID ? id_q : id_q + 1'b1;
        state_d = id_q == LAST_ID ? ST_IDLE : ST_REQUEST;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      id_q <= '0;
      byte_idx_q <= '0;
      tmo_q <= '0;
      frame_q <= '0;
      error_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      byte_idx_q <= byte_idx_d;
      tmo_q <= tmo_d;
      frame_q <= frame_d;
      error_q <= error_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_debug_frame_serializer.sv
// tb_debug_frame_serializer: directed dumps against a frame-level model of the serializer
module tb_debug_frame_serializer;
  import debug_frame_serializer_pkg::*;
  localparam logic [5:0] IDLE = 6'b111111;
  localparam int TMO_CYCLES = (1 << 4) - 1;
  logic i_clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_writing = 1'b0, i_tx_done = 1'b0;
  logic [31:0] i_frame_from_controller = '0;
  logic [5:0] o_request_select;
  logic [7:0] o_tx_data;
  logic o_tx_start, o_busy, o_done, o_error;

  debug_frame_serializer dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .i_start                (i_start),
    .o_request_select       (o_request_select),
    .i_frame_from_controller(i_frame_from_controller),
    .i_writing              (i_writing),
    .o_tx_data              (o_tx_data),
    .o_tx_start             (o_tx_start),
    .i_tx_done              (i_tx_done),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_error                (o_error)
  );

  always #5 i_clock = ~i_clock;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int resp_delay[4] = '{2, 2, 2, 2};
  int tx_delay = 1;
  bit spur_park = 0, spur_done = 0;

  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  int next_id = 0, req_len = 0, last_req_cyc = 0, dones = 0;
  bit out_pending = 0, m_err = 0;
  logic [7:0] held = '0;
  logic [5:0] prev_sel = IDLE;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic bit is_silent(logic [5:0] s);
    return s < 6'd4 && resp_delay[s[1:0]] < 0;
  endfunction

  function automatic int exp_len(logic [5:0] s);
    return s > 6'd3 ? 0 : (resp_delay[s[1:0]] < 0 ? TMO_CYCLES : resp_delay[s[1:0]] + 1);
  endfunction

  // controllers: answer resp_delay cycles after being selected; optional write while parked
  initial begin : controllers
    int cnt;
    logic [5:0] last;
    cnt = 0;
    last = IDLE;
    forever begin
      @(posedge i_clock);
      #1;
      if (o_request_select != IDLE) begin
        cnt = o_request_select == last ? cnt + 1 : 1;
        i_writing = o_request_select < 6'd4 && resp_delay[o_request_select[1:0]] >= 0
                    && cnt > resp_delay[o_request_select[1:0]];
        i_frame_from_controller = 32'h1122_3300 + 32'(o_request_select);
      end else begin
        cnt = 0;
        i_writing = spur_park && last != IDLE;
        i_frame_from_controller = spur_park && last != IDLE ? 32'hDEAD_BEEF : 32'h5A5A_5A5A;
      end
      last = o_request_select;
    end
  end

  // transmitter: done tx_delay cycles after each start, optionally a stray done one cycle later
  initial begin : transmitter
    int left;
    bit extra;
    left = 0;
    extra = 0;
    forever begin
      @(posedge i_clock);
      #1;
      i_tx_done = extra;
      extra = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          i_tx_done = 1'b1;
          extra = spur_done;
        end
      end
      if (o_tx_start) left = tx_delay;
    end
  end

  // compare process: select order, request lengths, byte stream, latency, stability, error, done
  always @(negedge i_clock) begin
    if (i_reset) begin
      out_pending = 0;
      prev_sel = IDLE;
      req_len = 0;
      m_err = 0;
      exp_q.delete();
    end else begin
      if (o_request_select != IDLE) begin
        if (prev_sel == IDLE) begin
          chk("select_id", 32'(o_request_select), 32'(next_id));
          if (next_id == 0) m_err = 0;
          req_len = 0;
        end else if (o_request_select != prev_sel)
          chk("select_spacing", 32'(o_request_select), 32'(prev_sel));
        req_len++;
        last_req_cyc = cyc;
      end else if (prev_sel != IDLE) begin
        chk("request_cycles", 32'(req_len), 32'(exp_len(prev_sel)));
        if (is_silent(prev_sel)) m_err = 1;
        next_id++;
      end
      if (out_pending) begin
        chk("tx_data_stable", 32'(o_tx_data), 32'(held));
        if (i_tx_done) out_pending = 0;
      end
      if (o_tx_start) begin
        chk("single_tx_start", 32'(out_pending), 0);
        if (seen.size() % 4 == 0) chk("first_byte_latency", 32'(cyc - last_req_cyc), 3);
        chk("tx_byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        seen.push_back(o_tx_data);
        held = o_tx_data;
        out_pending = 1;
      end
      if (o_done) begin
        chk("done_bytes_left", 32'(exp_q.size()), 0);
        chk("done_ids_served", 32'(next_id), 4);
        dones++;
      end
      chk("error_flag", 32'(o_error), 32'(m_err));
      prev_sel = o_request_select;
    end
  end

  task automatic arm(int d0, int d1, int d2, int d3);
    logic [31:0] f;
    resp_delay = '{d0, d1, d2, d3};
    exp_q.delete();
    seen.delete();
    next_id = 0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      f = resp_delay[k] < 0 ? 32'hFFFF_FFFF : 32'h1122_3300 + 32'(k);
      for (int b = 0; b < 4; b++) exp_q.push_back(f[8*b +: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge i_clock);
    #1 i_start = 1'b1;
    @(posedge i_clock);
    #1 i_start = 1'b0;
    @(negedge i_clock);
    chk("busy_after_start", 32'(o_busy), 1);
  endtask

  task automatic wait_done(string nm, int budget, bit spur_start);
    int n;
    n = 0;
    while (dones == 0 && n < budget) begin
      @(negedge i_clock);
      n++;
      i_start = spur_start && (n % 37 == 5);
    end
    i_start = 1'b0;
    repeat (3) @(negedge i_clock);
    chk(nm, 32'(dones), 1);
    chk("busy_after_done", 32'(o_busy), 0);
    chk("bytes_sent", 32'(seen.size()), 16);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_select", 32'(o_request_select), 32'(IDLE));
    chk("rst_tx_start", 32'(o_tx_start), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);

    arm(2, 2, 2, 2);
    tx_delay = 1;
    pulse_start();
    wait_done("normal_done", 2000, 0);
    chk("normal_b0", 32'(seen[0]), 32'h00);
    chk("normal_b1", 32'(seen[1]), 32'h33);
    chk("normal_b3", 32'(seen[3]), 32'h11);
    chk("normal_b4", 32'(seen[4]), 32'h01);
    chk("normal_b15", 32'(seen[15]), 32'h11);
    chk("normal_error", 32'(o_error), 0);

    arm(1, 3, -1, 0);
    tx_delay = 2;
    pulse_start();
    wait_done("timeout_done", 2000, 0);
    chk("timeout_b8", 32'(seen[8]), 32'hFF);
    chk("timeout_b11", 32'(seen[11]), 32'hFF);
    chk("timeout_b12", 32'(seen[12]), 32'h03);
    chk("timeout_b7", 32'(seen[7]), 32'h11);
    repeat (5) @(negedge i_clock);
    chk("timeout_error_sticky", 32'(o_error), 1);

    arm(2, 2, 2, 2);
    tx_delay = 100;
    pulse_start();
    chk("error_cleared_by_start", 32'(o_error), 0);
    wait_done("slow_done", 3000, 1);
    chk("slow_b5", 32'(seen[5]), 32'h33);

    arm(3, 2, 2, 1);
    tx_delay = 2;
    spur_park = 1;
    spur_done = 1;
    pulse_start();
    wait_done("spurious_done", 2000, 1);
    chk("spurious_b4", 32'(seen[4]), 32'h01);
    chk("spurious_b13", 32'(seen[13]), 32'h33);
    spur_park = 0;
    spur_done = 0;

    arm(2, 2, 2, 2);
    tx_delay = 3;
    pulse_start();
    n = 0;
    while (seen.size() < 6 && n < 500) begin
      @(negedge i_clock);
      n++;
    end
    chk("reached_ctrl1_byte1", 32'(seen.size()), 6);
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    chk("midrst_select", 32'(o_request_select), 32'(IDLE));
    chk("midrst_tx_start", 32'(o_tx_start), 0);
    chk("midrst_tx_data", 32'(o_tx_data), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_done", 32'(o_done), 0);
    chk("midrst_error", 32'(o_error), 0);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clock);
    chk("midrst_no_done", 32'(dones), 0);
    chk("midrst_idle", 32'(o_busy), 0);
    chk("midrst_no_more_bytes", 32'(seen.size()), 6);

    arm(2, 2, 2, 2);
    tx_delay = 1;
    pulse_start();
    wait_done("restart_done", 2000, 0);
    chk("restart_b0", 32'(seen[0]), 32'h00);
    chk("restart_b12", 32'(seen[12]), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/debug_frame_serializer.md
DEBUG_FRAME_SERIALIZER -- requirements
Module: debug_frame_serializer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NB_CONTROL_FRAME, 32, width of a frame returned by a debug controller.
- NB_BYTE, 8, width of one transmit byte.
- N_CONTROLLERS, 4, number of controllers polled; their IDs are 0..N_CONTROLLERS-1.
- NB_TIMEOUT, 4, width of the response-timeout counter.
- IDLE_SELECT, 6'b111111, request code that addresses no controller.

REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clock, in, 1, clock; all logic is on the rising edge.
- i_reset, in, 1, reset; synchronous, active-high.
- i_start, in, 1, one-cycle pulse that starts a full dump.
- o_request_select, out, 6, ID of the controller being addressed.
- i_frame_from_controller, in, NB_CONTROL_FRAME, frame from the addressed controller.
- i_writing, in, 1, high while the addressed controller presents a valid frame.
- o_tx_data, out, NB_BYTE, byte presented to the transmitter.
- o_tx_start, out, 1, one-cycle request to transmit o_tx_data.
- i_tx_done, in, 1, one-cycle pulse: the transmitter has finished the byte.
- o_busy, out, 1, high whenever the state is not IDLE.
- o_done, out, 1, one-cycle pulse when a dump completes.
- o_error, out, 1, sticky flag: at least one controller timed out.

Function
REQ-003 States SHALL be IDLE, REQUEST, PARK, LOAD, WAIT_TX and NEXT.
REQ-004 IDLE: drive o_request_select=IDLE_SELECT. On i_start, clear id to 0, clear o_error, then go to REQUEST.
REQ-005 i_start SHALL be ignored in every state except IDLE.
REQ-006 REQUEST: drive o_request_select=id and increment the timeout counter each cycle. Transitions:
- i_writing=1: latch i_frame_from_controller into frame_reg in that cycle, then go to PARK.
- Counter reaches 2^NB_TIMEOUT-1 with i_writing=0: latch all-ones into frame_reg, set o_error, then go to PARK.
REQ-007 PARK: drive IDLE_SELECT for exactly one cycle so the controller sees a fresh rising edge on its next request. Clear byte_idx and the timeout counter, then go to LOAD.
REQ-008 LOAD: drive o_tx_data=frame_reg[byte_idx*NB_BYTE +: NB_BYTE] (least significant byte first), pulse o_tx_start for one cycle, then go to WAIT_TX.
REQ-009 WAIT_TX: hold o_tx_data stable. Each i_tx_done pulse ends the current byte:
- byte_idx < NB_CONTROL_FRAME/NB_BYTE-1: increment byte_idx and go to LOAD.
- otherwise: go to NEXT.
REQ-010 i_tx_done SHALL be ignored in all states except WAIT_TX, including the LOAD cycle itself.
REQ-011 NEXT: if id==N_CONTROLLERS-1, pulse o_done and go to IDLE. Otherwise increment id and go to REQUEST.
REQ-012 Latency: the first o_tx_start occurs exactly 3 cycles after the i_writing sample cycle (PARK, then LOAD, then the pulse).
REQ-013 Frames SHALL be captured only in REQUEST. i_writing in any other state has no effect.
REQ-014 id SHALL be $clog2(N_CONTROLLERS) bits wide, zero-extended onto o_request_select. It never wraps mid-dump.

Reset
REQ-015 On reset, all outputs and state SHALL take these values: state=IDLE, o_request_select=IDLE_SELECT, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_error=0, id=0, byte_idx=0, timeout counter=0, frame_reg=0.
REQ-016 Reset asserted mid-dump SHALL abort the dump in the same edge, with no o_done pulse. Further i_tx_done pulses SHALL be ignored.

Structure
REQ-017 The shared debug package SHALL hold IDLE_SELECT, the state encoding, and the controller ID constants, which are also used by the debug controllers.
REQ-018 One sub-module, debug_byte_mux, SHALL implement the byte_idx-to-byte selection (combinational). The FSM, counters and registers stay in the top module.

Verification
REQ-019 Normal dump: N_CONTROLLERS=4. Controller k asserts i_writing 2 cycles after select==k, with frame 32'h1122_3300+k. Required response:
- 16 bytes in order 00,33,22,11, 01,33,22,11, ...
- one o_done pulse; o_error=0.
REQ-020 Timeout: controller 2 never asserts i_writing. Required response:
- after 15 REQUEST cycles, bytes FF,FF,FF,FF are sent for controller 2;
- o_error=1 stays set until the next i_start;
- controller 3 is still serviced.
REQ-021 Slow transmitter: i_tx_done arrives 100 cycles after each o_tx_start. Required response:
- o_tx_data is stable throughout WAIT_TX;
- exactly one o_tx_start per byte.
REQ-022 Spurious inputs:
- i_start pulses while busy cause no restart;
- i_tx_done in the LOAD cycle causes no byte skip;
- i_writing during PARK causes no re-capture.
REQ-023 Reset during the second byte of controller 1: outputs match REQ-015 on the next cycle. A new i_start then restarts from id 0.
REQ-024 Select spacing: o_request_select is IDLE_SELECT for at least 1 cycle between consecutive controller IDs.
